// File: rtl/qpix_serial_cfg_seq_pkg.sv
// Shared types and constants for the QPix serial configuration sequencer.
// Holds the FSM state encoding, interface indices and SIM_FAST timing resolution.
package qpix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_SR,
        ST_GAP,
        ST_SHIFT,
        ST_LOADP,
        ST_RB_PRIME,
        ST_RB_SHIFT,
        ST_FIN
    } state_t;

    localparam int IF1 = 0;
    localparam int IF2 = 1;

    localparam int FAST_CLK_DIV    = 2;
    localparam int FAST_LOAD_PULSE = 8;

    function automatic int eff_clk_div(input int sim_fast, input int clk_div);
        return (sim_fast != 0) ? FAST_CLK_DIV : clk_div;
    endfunction

    function automatic int eff_load_pulse(input int sim_fast, input int load_pulse);
        return (sim_fast != 0) ? FAST_LOAD_PULSE : load_pulse;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One-hot pad mask for the selected interface; the other bit is always 0.
    function automatic logic [1:0] if_mask(input logic sel);
        return sel ? 2'(1 << IF2) : 2'(1 << IF1);
    endfunction

endpackage

// File: rtl/qpix_bitclk_gen.sv
// Half-period tick and serial clock level generator for CLKin / CLKin2.
// Restarts at the first half whenever en falls; inv selects which half is high.
module qpix_bitclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic inv,
    output logic tick,
    output logic phase_hi
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          second_half;

    assign tick     = en && (cnt == CW'(CLK_DIV - 1));
    assign phase_hi = en && (second_half ^ inv);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            second_half <= 1'b0;
        end else if (!en) begin
            cnt         <= '0;
            second_half <= 1'b0;
        end else if (tick) begin
            cnt         <= '0;
            second_half <= ~second_half;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qpix_serial_cfg_seq.sv
// Start/done sequencer for the two QPix serial configuration interfaces:
// SR load, MSB-first shift, loadData one-shot, optional CLKin2 readback and compare.
module qpix_serial_cfg_seq
    import qpix_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CLK_DIV    = 25,
    parameter int LOAD_PULSE = 5000,
    parameter int SIM_FAST   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sel_if,
    input  logic              verify,
    input  logic              abort,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        sr_load,
    output logic [1:0]        sclk,
    output logic [1:0]        sdata,
    output logic [1:0]        load_data,
    output logic [1:0]        ser_out_cnt,
    output logic [1:0]        clkin2,
    input  logic [1:0]        sdo
);

    localparam int CD = eff_clk_div(SIM_FAST, CLK_DIV);
    localparam int LP = eff_load_pulse(SIM_FAST, LOAD_PULSE);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int PW = $clog2(max_int(CD, LP) + 1);

    state_t            state;
    logic              sel_q;
    logic              verify_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] rd_shift;
    logic [BW-1:0]     bcnt;
    logic [PW-1:0]     pcnt;

    logic       gen_en;
    logic       gen_inv;
    logic       gen_tick;
    logic       gen_hi;
    logic [1:0] sel_mask;

    assign gen_en   = (state == ST_SHIFT) || (state == ST_RB_PRIME) || (state == ST_RB_SHIFT);
    assign gen_inv  = (state != ST_SHIFT);
    assign sel_mask = if_mask(sel_q);

    qpix_bitclk_gen #(.CLK_DIV(CD)) u_bitclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (gen_en),
        .inv      (gen_inv),
        .tick     (gen_tick),
        .phase_hi (gen_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sel_q       <= 1'b0;
            verify_q    <= 1'b0;
            wdata_q     <= '0;
            shreg       <= '0;
            rd_shift    <= '0;
            bcnt        <= '0;
            pcnt        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mismatch    <= 1'b0;
            rdata       <= '0;
            sr_load     <= '0;
            sclk        <= '0;
            sdata       <= '0;
            load_data   <= '0;
            ser_out_cnt <= '0;
            clkin2      <= '0;
        end else begin
            done    <= 1'b0;
            sr_load <= '0;
            if (abort) begin
                // Abort drops everything, including a start in the same cycle.
                state       <= ST_IDLE;
                busy        <= 1'b0;
                sclk        <= '0;
                sdata       <= '0;
                load_data   <= '0;
                ser_out_cnt <= '0;
                clkin2      <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            sel_q    <= sel_if;
                            verify_q <= verify;
                            wdata_q  <= wdata;
                            shreg    <= wdata;
                            rdata    <= '0;
                            mismatch <= 1'b0;
                            busy     <= 1'b1;
                            sr_load  <= if_mask(sel_if);
                            state    <= ST_LOAD_SR;
                        end
                    end
                    ST_LOAD_SR: state <= ST_GAP;
                    ST_GAP: begin
                        sdata <= shreg[DATA_W-1] ? sel_mask : 2'b00;
                        bcnt  <= '0;
                        state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (gen_tick && !gen_hi) begin
                            sclk <= sel_mask;
                        end else if (gen_tick) begin
                            sclk <= '0;
                            if (bcnt == BW'(DATA_W - 1)) begin
                                sdata     <= '0;
                                load_data <= sel_mask;
                                pcnt      <= '0;
                                state     <= ST_LOADP;
                            end else begin
                                sdata <= shreg[DATA_W-2] ? sel_mask : 2'b00;
                                shreg <= {shreg[DATA_W-2:0], 1'b0};
                                bcnt  <= bcnt + 1'b1;
                            end
                        end
                    end
                    ST_LOADP: begin
                        if (pcnt == PW'(LP - 1)) begin
                            load_data <= '0;
                            if (verify_q) begin
                                clkin2 <= sel_mask;
                                state  <= ST_RB_PRIME;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_FIN;
                            end
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                    ST_RB_PRIME: begin
                        if (gen_tick && gen_hi) begin
                            clkin2 <= '0;
                        end else if (gen_tick) begin
                            clkin2      <= sel_mask;
                            ser_out_cnt <= sel_mask;
                            bcnt        <= '0;
                            state       <= ST_RB_SHIFT;
                        end
                    end
                    ST_RB_SHIFT: begin
                        if (gen_tick && gen_hi) begin
                            rd_shift <= {rd_shift[DATA_W-2:0], sdo[sel_q]};
                            clkin2   <= '0;
                        end else if (gen_tick) begin
                            if (bcnt == BW'(DATA_W - 1)) begin
                                ser_out_cnt <= '0;
                                state       <= ST_FIN;
                            end else begin
                                clkin2 <= sel_mask;
                                bcnt   <= bcnt + 1'b1;
                            end
                        end
                    end
                    ST_FIN: begin
                        // The write path arrives with done already set; readback spends one compare cycle first.
                        if (!done && verify_q) begin
                            done     <= 1'b1;
                            rdata    <= rd_shift;
                            mismatch <= (rd_shift != wdata_q);
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qpix_serial_cfg_seq.sv
// Directed bench for qpix_serial_cfg_seq with a looped-back 32-bit SR model per interface.
module tb_qpix_serial_cfg_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel_if = 1'b0;
    logic        verify = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, mismatch;
    logic [31:0] rdata;
    logic [1:0]  sr_load, sclk, sdata, load_data, ser_out_cnt, clkin2, sdo;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    qpix_serial_cfg_seq #(
        .DATA_W(32), .CLK_DIV(25), .LOAD_PULSE(5000), .SIM_FAST(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_if(sel_if), .verify(verify),
        .abort(abort), .wdata(wdata), .busy(busy), .done(done), .mismatch(mismatch),
        .rdata(rdata), .sr_load(sr_load), .sclk(sclk), .sdata(sdata),
        .load_data(load_data), .ser_out_cnt(ser_out_cnt), .clkin2(clkin2), .sdo(sdo)
    );

    // Behavioural QPix SR: shift on CLKin rise, latch on loadData, prime and read back on CLKin2.
    logic corrupt = 1'b0;
    for (genvar g = 0; g < 2; g++) begin : g_sr
        logic [31:0] sr = '0;
        logic [31:0] cfg = '0;
        logic [31:0] outr = '0;
        always @(posedge sclk[g]) sr <= {sr[30:0], sdata[g]};
        always @(posedge load_data[g]) cfg <= sr;
        always @(clkin2[g]) begin
            if (clkin2[g] && !ser_out_cnt[g])
                outr <= corrupt ? (cfg & 32'hFFFF_FFFE) : cfg;
            else if (!clkin2[g] && ser_out_cnt[g])
                outr <= {outr[30:0], 1'b0};
        end
    end
    assign sdo = {g_sr[1].outr[31], g_sr[0].outr[31]};

    // Pulse and level counters, cleared at the start of each transaction.
    logic       mon_clr = 1'b0;
    int         n_sclk[2], n_clk2[2], n_prime[2], n_ld[2], n_soc[2], n_srl[2];
    int         n_done;
    logic [1:0] sclk_p = '0;
    logic [1:0] clk2_p = '0;
    always @(posedge clk) begin
        if (mon_clr) begin
            for (int i = 0; i < 2; i++) begin
                n_sclk[i] = 0; n_clk2[i] = 0; n_prime[i] = 0;
                n_ld[i] = 0; n_soc[i] = 0; n_srl[i] = 0;
            end
            n_done = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sclk[i] && !sclk_p[i]) n_sclk[i]++;
                if (clkin2[i] && !clk2_p[i]) n_clk2[i]++;
                if (clkin2[i] && !clk2_p[i] && !ser_out_cnt[i]) n_prime[i]++;
                if (load_data[i]) n_ld[i]++;
                if (ser_out_cnt[i]) n_soc[i]++;
                if (sr_load[i]) n_srl[i]++;
            end
            if (done) n_done++;
        end
        sclk_p = sclk;
        clk2_p = clkin2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pads();
        return {sr_load, sclk, sdata, load_data, ser_out_cnt, clkin2};
    endfunction

    // Runs one transaction; lat is the cycle (start cycle = 0) where done is seen, -1 if never.
    task automatic run_txn(input logic s, input logic v, input logic [31:0] w,
                           input int abort_at, input int start2_at, input int rst_at,
                           input int limit, output int lat, output logic mm);
        lat = -1;
        mm  = 1'b0;
        @(negedge clk);
        sel_if = s; verify = v; wdata = w; start = 1'b1; mon_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; mon_clr = 1'b0;
        for (int n = 1; n <= limit; n++) begin
            if (lat < 0 && done) begin
                lat = n;
                mm  = mismatch;
            end
            if (lat >= 0) break;
            if (n == abort_at + 1) begin
                check("abort_load_data", 32'(load_data), 32'h0);
                check("abort_busy", 32'(busy), 32'h0);
                check("abort_pads", 32'(pads()), 32'h0);
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_async_pads", 32'(pads()), 32'h0);
                check("rst_async_flags", 32'({busy, done, mismatch}), 32'h0);
                check("rst_async_rdata", rdata, 32'h0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            start = (n == start2_at);
            if (start) begin
                sel_if = ~s; verify = ~v; wdata = ~w;
            end
            abort = (n == abort_at);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        if (lat >= 0) begin
            @(negedge clk);
            check("busy_after_done", 32'(busy), 32'h0);
        end
    endtask

    int   lat;
    logic mm;

    initial begin
        // 1: reset
        repeat (5) @(negedge clk);
        check("reset_pads", 32'(pads()), 32'h0);
        check("reset_flags", 32'({busy, done, mismatch}), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_release", 32'({busy, done, pads()}), 32'h0);

        // start together with abort in IDLE is dropped
        start = 1'b1; abort = 1'b1; sel_if = 1'b0; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'h0);
        check("start_abort_srload", 32'(sr_load), 32'h0);

        // 2: write only on interface 1
        run_txn(1'b0, 1'b0, 32'h1234_5678, -1, -1, -1, 200, lat, mm);
        check("w_latency", 32'(lat), 32'd139);
        check("w_sclk0", 32'(n_sclk[0]), 32'd32);
        check("w_model0", g_sr[0].cfg, 32'h1234_5678);
        check("w_load0", 32'(n_ld[0]), 32'd8);
        check("w_srload0", 32'(n_srl[0]), 32'd1);
        check("w_if2_quiet", 32'(n_sclk[1] + n_ld[1] + n_srl[1] + n_clk2[1] + n_soc[1]), 32'd0);
        check("w_no_readback", 32'(n_clk2[0] + n_soc[0]), 32'd0);
        check("w_mismatch", 32'(mm), 32'h0);
        check("w_one_done", 32'(n_done), 32'd1);

        // 3: write and verify on interface 2
        run_txn(1'b1, 1'b1, 32'hA0A0_A0AF, -1, -1, -1, 350, lat, mm);
        check("v_latency", 32'(lat), 32'd272);
        check("v_rdata", rdata, 32'hA0A0_A0AF);
        check("v_mismatch", 32'(mm), 32'h0);
        check("v_clkin2_1", 32'(n_clk2[1]), 32'd33);
        check("v_prime_1", 32'(n_prime[1]), 32'd1);
        check("v_soc_cycles", 32'(n_soc[1]), 32'd128);
        check("v_if1_quiet", 32'(n_sclk[0] + n_ld[0] + n_clk2[0] + n_soc[0]), 32'd0);

        // 4: readback bit 0 stuck low
        corrupt = 1'b1;
        run_txn(1'b1, 1'b1, 32'hA0A0_A0AF, -1, -1, -1, 350, lat, mm);
        corrupt = 1'b0;
        check("c_latency", 32'(lat), 32'd272);
        check("c_rdata", rdata, 32'hA0A0_A0AE);
        check("c_mismatch", 32'(mm), 32'h1);

        // 5a: second start mid-SHIFT ignored
        run_txn(1'b0, 1'b0, 32'hCAFE_F00D, -1, 50, -1, 200, lat, mm);
        check("b_latency", 32'(lat), 32'd139);
        check("b_one_done", 32'(n_done), 32'd1);
        check("b_model0", g_sr[0].cfg, 32'hCAFE_F00D);
        check("b_if2_quiet", 32'(n_sclk[1] + n_srl[1]), 32'd0);

        // 5b: abort during LOADP, then a fresh transaction
        run_txn(1'b1, 1'b1, 32'h1357_9BDF, 133, -1, -1, 300, lat, mm);
        check("a_no_done", 32'(lat), 32'hFFFF_FFFF);
        check("a_done_count", 32'(n_done), 32'd0);
        run_txn(1'b1, 1'b1, 32'h5A5A_0FF0, -1, -1, -1, 350, lat, mm);
        check("a_fresh_latency", 32'(lat), 32'd272);
        check("a_fresh_rdata", rdata, 32'h5A5A_0FF0);
        check("a_fresh_mismatch", 32'(mm), 32'h0);

        // 6: reset during RB_SHIFT, then a clean transaction
        run_txn(1'b0, 1'b1, 32'hDEAD_BEEF, -1, -1, 200, 350, lat, mm);
        run_txn(1'b0, 1'b1, 32'h0F1E_2D3C, -1, -1, -1, 350, lat, mm);
        check("r_latency", 32'(lat), 32'd272);
        check("r_rdata", rdata, 32'h0F1E_2D3C);
        check("r_mismatch", 32'(mm), 32'h0);
        check("r_clkin2_0", 32'(n_clk2[0]), 32'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
